div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as in the codebase: clock and reset.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: data_operandA  input  32  signed dividend, two's complement.
REQ-005 Port: data_operandB  input  32  signed divisor, two's complement.
REQ-006 Port: ctrl_DIV  input  1  start strobe, sampled on the rising clock edge.
REQ-007 Port: data_result  output  32  signed quotient, registered.
REQ-008 Port: data_exception  output  1  divide-by-zero flag, valid only while data_resultRDY=1.
REQ-009 Port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 Parameter: none; all widths are fixed at 32 bits.

Function
REQ-011 States SHALL be IDLE, SETUP, RUN and DONE; reset forces IDLE.
REQ-012 When ctrl_DIV=1 at an edge, in any state, the block SHALL latch A and B, clear the iteration counter, and enter SETUP.
REQ-013 SETUP (1 cycle) SHALL:
- store |A| and |B| as 32-bit unsigned magnitudes, with |0x80000000| = 0x80000000;
- record sign = A[31] XOR B[31];
- record divzero = (B == 0);
- clear the 33-bit partial remainder.
REQ-014 RUN SHALL perform exactly 32 restoring iterations, one per cycle, MSB of |A| first.
REQ-015 Each RUN iteration SHALL:
- shift the remainder left by one and bring in the next dividend bit;
- subtract |B| from the remainder;
- if the result is non-negative, keep it and set the quotient bit to 1;
- otherwise restore the remainder and set the quotient bit to 0.
REQ-016 The 5-bit iteration counter SHALL wrap from 31 to 0; on that wrap the FSM SHALL enter DONE.
REQ-017 DONE (1 cycle) SHALL drive data_resultRDY=1, then return to IDLE.
REQ-018 data_result and data_exception SHALL update on the edge entering DONE.
REQ-019 Latency: ctrl_DIV sampled at edge k SHALL give data_resultRDY=1 between edges k+34 and k+35, i.e. exactly one cycle.
REQ-020 Quotient SHALL truncate toward zero; if sign=1, data_result SHALL equal the two's-complement negation of the magnitude quotient.
REQ-021 -2^31 / -1 SHALL yield data_result=0x80000000 with data_exception=0 (wrap, no flag).
REQ-022 If divzero=1, the block SHALL still take the full latency, then drive data_result=0 and data_exception=1 in the DONE cycle.
REQ-023 data_exception SHALL be 0 in every cycle where data_resultRDY=0.
REQ-024 data_result SHALL hold its last value until the next DONE entry.
REQ-025 ctrl_DIV=1 in any of the following cases SHALL restart with the new operands and emit no pulse for the aborted operation:
- during SETUP or RUN;
- on the same edge the FSM would enter DONE.
REQ-026 ctrl_DIV=1 during DONE SHALL still emit the current pulse, then go to SETUP rather than IDLE.
REQ-027 Operand inputs SHALL be ignored except on edges where ctrl_DIV=1.

Reset
REQ-028 Asserting reset SHALL, without waiting for a clock edge, force:
- state to IDLE;
- data_result=0, data_exception=0, data_resultRDY=0;
- the counter and all internal registers to 0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation; no data_resultRDY pulse for that operation SHALL appear after reset is released.
REQ-030 After reset is released, the block SHALL remain idle until ctrl_DIV=1.

Verification
REQ-031 A=100, B=7, ctrl_DIV pulse at edge k -> data_resultRDY=1 only between edges k+34 and k+35, data_result=14, data_exception=0.
REQ-032 A=-100, B=7 -> data_result=0xFFFFFFF2 (-14); A=-7, B=-2 -> data_result=3; both with data_exception=0.
REQ-033 A=5, B=0 -> at k+34, data_exception=1 and data_result=0; both outputs return to 0 after one cycle.
REQ-034 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=0; A=0x80000000, B=1 -> data_result=0x80000000.
REQ-035 Start 100/7, re-strobe 50/5 at k+10 -> single pulse at k+44 with data_result=10, and no pulse at k+34.
REQ-036 Start 100/7, assert reset at k+20 for 2 cycles -> all outputs are 0 immediately, no pulse appears through k+60, and a new 9/3 operation returns 3.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle signed 32-bit divider: restoring algorithm, one quotient bit per cycle.
// Strobe to completion pulse is 34 cycles; a new strobe always restarts the operation.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t      state_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] quo_reg;      // holds |A| initially; quotient bits shift in from the LSB
    logic [31:0] mag_b_reg;
    logic [32:0] rem_reg;
    logic [4:0]  count_reg;
    logic        sign_reg;
    logic        divzero_reg;

    logic [33:0] shifted;
    logic [33:0] diff;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_signed;

    always_comb begin
        shifted = {rem_reg, quo_reg[31]};
        diff    = shifted - {2'b00, mag_b_reg};
        if (!diff[33]) begin
            rem_next = diff[32:0];
            quo_next = {quo_reg[30:0], 1'b1};
        end else begin
            rem_next = shifted[32:0];
            quo_next = {quo_reg[30:0], 1'b0};
        end
        // Negation of 0x80000000 wraps to itself, which is the desired magnitude.
        mag_a      = a_reg[31] ? (~a_reg + 32'd1) : a_reg;
        mag_b      = b_reg[31] ? (~b_reg + 32'd1) : b_reg;
        quo_signed = sign_reg ? (~quo_next + 32'd1) : quo_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            quo_reg        <= '0;
            mag_b_reg      <= '0;
            rem_reg        <= '0;
            count_reg      <= '0;
            sign_reg       <= 1'b0;
            divzero_reg    <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            // The pulse follows the DONE state by one edge, so a strobe in DONE still gets it.
            data_resultRDY <= (state_reg == DONE);
            data_exception <= (state_reg == DONE) && divzero_reg;
            if (ctrl_DIV) begin
                a_reg     <= data_operandA;
                b_reg     <= data_operandB;
                count_reg <= '0;
                state_reg <= SETUP;
            end else begin
                case (state_reg)
                    IDLE: state_reg <= IDLE;
                    SETUP: begin
                        quo_reg     <= mag_a;
                        mag_b_reg   <= mag_b;
                        sign_reg    <= a_reg[31] ^ b_reg[31];
                        divzero_reg <= (b_reg == 32'd0);
                        rem_reg     <= '0;
                        state_reg   <= RUN;
                    end
                    RUN: begin
                        quo_reg   <= quo_next;
                        rem_reg   <= rem_next;
                        count_reg <= count_reg + 5'd1;
                        if (count_reg == 5'd31) begin
                            state_reg   <= DONE;
                            data_result <= divzero_reg ? 32'd0 : quo_signed;
                        end
                    end
                    DONE: state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of signed divisions with hand-computed quotients,
// plus restart, strobe-during-DONE and mid-operation reset sequences.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        x;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Presents operands with a strobe sampled at the next rising edge (edge k), then scrambles them.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Samples outputs 1 time unit after edges k+from_n .. k+to_n; pulse_n < 0 means no pulse expected.
    task automatic monitor(input string tag, input int from_n, input int to_n, input int pulse_n,
                           input logic [31:0] exp_q, input logic exp_x);
        for (int n = from_n; n <= to_n; n++) begin
            @(posedge clock);
            #1;
            chk($sformatf("%s rdy@k+%0d", tag, n), {31'd0, data_resultRDY}, {31'd0, n == pulse_n});
            chk($sformatf("%s exc@k+%0d", tag, n), {31'd0, data_exception},
                {31'd0, (n == pulse_n) ? exp_x : 1'b0});
            if (n == pulse_n) begin
                chk($sformatf("%s result", tag), data_result, exp_q);
                $display("txn %s: result=%h exc=%b at k+%0d", tag, data_result, data_exception, n);
            end
        end
        if (pulse_n >= from_n && pulse_n < to_n)
            chk($sformatf("%s result hold", tag), data_result, exp_q);
    endtask

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          32'd14,          1'b0};
        vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFFFFF2,    1'b0};
        vecs[2]  = '{-32'sd7,        -32'sd2,        32'd3,           1'b0};
        vecs[3]  = '{32'd5,          32'd0,          32'd0,           1'b1};
        vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,    1'b0};
        vecs[5]  = '{32'h80000000,   32'd1,          32'h80000000,    1'b0};
        vecs[6]  = '{32'd7,          -32'sd100,      32'd0,           1'b0};
        vecs[7]  = '{32'd0,          32'd5,          32'd0,           1'b0};
        vecs[8]  = '{32'h7FFFFFFF,   32'd2,          32'h3FFFFFFF,    1'b0};
        vecs[9]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,    1'b0};
        vecs[10] = '{32'h80000000,   32'h80000000,   32'd1,           1'b0};
        vecs[11] = '{32'd12345678,   -32'sd3,        -32'sd4115226,   1'b0};
        vecs[12] = '{32'h80000000,   32'd2,          32'hC0000000,    1'b0};

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exc", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        monitor("idle", 1, 5, -1, 32'd0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            start(vecs[i].a, vecs[i].b);
            monitor($sformatf("vec%0d %0d/%0d", i, $signed(vecs[i].a), $signed(vecs[i].b)),
                    1, 36, 34, vecs[i].q, vecs[i].x);
        end

        // Re-strobe during RUN: the first operation must never complete.
        start(32'd100, 32'd7);
        monitor("abort-run old", 1, 9, -1, 32'd0, 1'b0);
        start(32'd50, 32'd5);
        monitor("abort-run new", 1, 40, 34, 32'd10, 1'b0);

        // Re-strobe on the edge that would enter DONE.
        start(32'd100, 32'd7);
        monitor("abort-done old", 1, 32, -1, 32'd0, 1'b0);
        start(32'd9, 32'd3);
        monitor("abort-done new", 1, 36, 34, 32'd3, 1'b0);

        // Strobe during DONE: current pulse still appears, then the new operation runs.
        start(32'd100, 32'd7);
        monitor("in-done old", 1, 33, -1, 32'd0, 1'b0);
        start(32'd50, 32'd5);
        chk("in-done old rdy", {31'd0, data_resultRDY}, 32'd1);
        chk("in-done old result", data_result, 32'd14);
        $display("txn in-done old: result=%h exc=%b", data_result, data_exception);
        monitor("in-done new", 1, 36, 34, 32'd10, 1'b0);

        // Reset mid-operation, asserted between edges: outputs clear at once, no pulse afterwards.
        start(32'd100, 32'd7);
        monitor("reset-mid", 1, 20, -1, 32'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset result", data_result, 32'd0);
        chk("async reset exc", {31'd0, data_exception}, 32'd0);
        chk("async reset rdy", {31'd0, data_resultRDY}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        monitor("post-reset", 23, 60, -1, 32'd0, 1'b0);
        start(32'd9, 32'd3);
        monitor("post-reset 9/3", 1, 36, 34, 32'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
